// File: rtl/alu_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_multiciclo_if
// Purpose  : request/result bundle between an ALU client and alu_multiciclo.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_multiciclo_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] C_alto;
  logic [6:0]       Flags;
  logic [1:0]       comparacao_resultado;
  logic             ALU_Cout;

  modport master (
    output start, ALU_Sel, A, B,
    input  busy, done, C, C_alto, Flags, comparacao_resultado, ALU_Cout
  );

  modport slave (
    input  start, ALU_Sel, A, B,
    output busy, done, C, C_alto, Flags, comparacao_resultado, ALU_Cout
  );
endinterface
`default_nettype wire

// File: rtl/alu_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : alu_multiciclo
// Purpose  : multi-cycle ALU; single-cycle arith/logic ops plus shift-add MUL
//            and restoring DIV/MOD, the latter only when ALU_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multiciclo #(
  parameter int WIDTH = 8
) (
  input wire              clk,
  input wire              rst,
  alu_multiciclo_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h4, OP_CMP = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7;
  localparam logic [3:0] OP_NOTA = 4'h8, OP_NOTB = 4'h9, OP_XOR = 4'hA, OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOR  = 4'hC, OP_XNOR = 4'hD;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FIM = 2'd2} state_t;
`endif

  state_t           r_state, w_state_nx;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_c, w_calto;
  logic [6:0]       w_flags;
  logic [1:0]       w_cmp;
  logic             w_cout, w_err, w_iter, w_load_single, w_load_iter;

  assign w_add = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle results are computed straight from the inputs at the accepting edge
  always_comb begin
    w_c     = '0;
    w_calto = '0;
    w_flags = '0;
    w_cmp   = 2'b00;
    w_cout  = 1'b0;
    w_err   = 1'b0;
    case (bus.ALU_Sel)
      OP_ADD: begin
        w_c        = w_add[WIDTH-1:0];
        w_cout     = w_add[WIDTH];
        w_flags[5] = w_add[WIDTH];
        w_flags[2] = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_add[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        w_c        = w_sub[WIDTH-1:0];
        w_cout     = w_sub[WIDTH];
        w_flags[5] = (bus.A < bus.B);
        w_flags[2] = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_sub[WIDTH-1] != bus.A[WIDTH-1]);
      end
`ifdef ALU_MULDIV_EN
      OP_MUL:         w_err = 1'b0;
      OP_DIV, OP_MOD: w_err = (bus.B == '0);
`endif
      OP_CMP: begin
        w_flags[2] = (bus.A == bus.B);
        w_cmp      = (bus.A > bus.B) ? 2'b01 : ((bus.A < bus.B) ? 2'b10 : 2'b00);
      end
      OP_AND:  w_c = bus.A & bus.B;
      OP_OR:   w_c = bus.A | bus.B;
      OP_NOTA: w_c = ~bus.A;
      OP_NOTB: w_c = ~bus.B;
      OP_XOR:  w_c = bus.A ^ bus.B;
      OP_NAND: w_c = ~(bus.A & bus.B);
      OP_NOR:  w_c = ~(bus.A | bus.B);
      OP_XNOR: w_c = ~(bus.A ^ bus.B);
      default: w_err = 1'b1;
    endcase
    if (w_err) begin
      w_c     = ALL_ONES;
      w_calto = ALL_ONES;
      w_flags = 7'h7F;
      w_cmp   = 2'b00;
      w_cout  = 1'b0;
    end else if (bus.ALU_Sel != OP_CMP) begin
      w_flags[6] = w_c[WIDTH-1];
      w_flags[4] = (w_c == '0);
      w_flags[3] = ^w_c;
    end
  end

`ifdef ALU_MULDIV_EN
  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [3:0]       r_sel;
  logic [WIDTH-1:0] r_m, r_hi, r_lo, w_hi_nx, w_lo_nx, w_diff, w_ic, w_ica;
  logic [WIDTH:0]   w_mul_sum, w_shift;
  logic [CW-1:0]    r_cnt;
  logic [6:0]       w_iflags;
  logic             w_ge;

  assign w_iter      = (bus.ALU_Sel == OP_MUL) ||
                       (((bus.ALU_Sel == OP_DIV) || (bus.ALU_Sel == OP_MOD)) && (bus.B != '0));
  assign w_load_iter = (r_state == ITER) && (r_cnt == CNT_LAST);
  assign bus.busy    = (r_state == ITER);

  // r_hi:r_lo is the shared product / remainder:quotient register pair
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_m});
  assign w_diff    = w_shift[WIDTH-1:0] - r_m;

  always_comb begin
    w_hi_nx = w_mul_sum[WIDTH:1];
    w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_sel != OP_MUL) begin
      w_hi_nx = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_comb begin
    w_ic     = w_lo_nx;
    w_ica    = w_hi_nx;
    w_iflags = '0;
    if (r_sel == OP_MOD) begin
      w_ic  = w_hi_nx;
      w_ica = w_lo_nx;
    end
    w_iflags[4] = (w_ic == '0);
    w_iflags[3] = ^w_ic;
    w_iflags[2] = (r_sel == OP_MUL) && (w_hi_nx != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= OP_ADD;
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if ((r_state == IDLE) && bus.start && w_iter) begin
      r_sel <= bus.ALU_Sel;
      r_m   <= (bus.ALU_Sel == OP_MUL) ? bus.A : bus.B;
      r_lo  <= (bus.ALU_Sel == OP_MUL) ? bus.B : bus.A;
      r_hi  <= '0;
      r_cnt <= '0;
    end else if (r_state == ITER) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_iter      = 1'b0;
  assign w_load_iter = 1'b0;
  assign bus.busy    = 1'b0;
`endif

  assign w_load_single = (r_state == IDLE) && bus.start && !w_iter;
  assign bus.done      = (r_state == FIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: begin
        if (w_load_single) w_state_nx = FIM;
`ifdef ALU_MULDIV_EN
        else if (bus.start) w_state_nx = ITER;
      end
      ITER: begin
        if (w_load_iter) w_state_nx = FIM;
`endif
      end
      FIM:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.C                    <= '0;
      bus.C_alto               <= '0;
      bus.Flags                <= '0;
      bus.comparacao_resultado <= 2'b00;
      bus.ALU_Cout             <= 1'b0;
    end else if (w_load_single) begin
      bus.C                    <= w_c;
      bus.C_alto               <= w_calto;
      bus.Flags                <= w_flags;
      bus.comparacao_resultado <= w_cmp;
      bus.ALU_Cout             <= w_cout;
`ifdef ALU_MULDIV_EN
    end else if (w_load_iter) begin
      bus.C                    <= w_ic;
      bus.C_alto               <= w_ica;
      bus.Flags                <= w_iflags;
      bus.comparacao_resultado <= 2'b00;
      bus.ALU_Cout             <= 1'b0;
`endif
    end
  end
endmodule
`default_nettype wire
